// File: rtl/fsm_counter_ctrl.sv
// fsm_counter_ctrl
//   Up/down step counter between 0 and MAX_COUNT, advanced by a clock-enable
//   tick from an internal rate divider. It supports pause, abort (a second go
//   press), auto-repeat and a one-clock done pulse. Everything runs on clk.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   go           async level; synchronised, rising edge starts or aborts a run
//   pause        async level; synchronised, freezes the count while high
//   dir          0 = count up to MAX_COUNT, 1 = count down to 0 (latched at start)
//   auto_repeat  1 = reload and run again after each completed sequence
//   count        current count value
//   busy         high in RUN or PAUSE
//   done         high for the single clock spent in DONE
//   state        IDLE=0, RUN=1, PAUSE=2, DONE=3
module fsm_counter_ctrl #(
  parameter int unsigned CNT_WIDTH = 4,
  parameter int unsigned MAX_COUNT = 15,
  parameter int unsigned CLK_DIV   = 1500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 pause,
  input  logic                 dir,
  input  logic                 auto_repeat,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]     DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Synchroniser and edge-detect flops
  logic go_meta_q, go_sync_q, go_prev_q, go_rise_q;
  logic pause_meta_q, pause_sync_q;
  logic go_rise_d;

  // Main FSM / datapath flops
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 dir_q, dir_d;

  logic                 tick;
  logic [CNT_WIDTH-1:0] start_val;
  logic [CNT_WIDTH-1:0] end_val;

  // Rising-edge detect of the synchronised go level; registered below so a
  // go edge reaches the FSM three clocks after the raw input rises.
  always_comb begin
    go_rise_d = go_sync_q & ~go_prev_q;
  end

  // Two-flop synchronisers for go and pause, plus the registered go edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_meta_q    <= 1'b0;
      go_sync_q    <= 1'b0;
      go_prev_q    <= 1'b0;
      go_rise_q    <= 1'b0;
      pause_meta_q <= 1'b0;
      pause_sync_q <= 1'b0;
    end else begin
      go_meta_q    <= go;
      go_sync_q    <= go_meta_q;
      go_prev_q    <= go_sync_q;
      go_rise_q    <= go_rise_d;
      pause_meta_q <= pause;
      pause_sync_q <= pause_meta_q;
    end
  end

  assign tick      = (div_q == DIV_LAST);
  assign start_val = dir_q ? CNT_MAX : CNT_ZERO;
  assign end_val   = dir_q ? CNT_ZERO : CNT_MAX;

  // Next-state and datapath logic. The divider free-runs unless a run is
  // (re)started, so the first step of every run lands CLK_DIV clocks later.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    div_d   = tick ? DIV_ZERO : (div_q + DIV_ONE);
    case (state_q)
      S_IDLE: begin
        if (go_rise_q) begin
          dir_d   = dir;
          count_d = dir ? CNT_MAX : CNT_ZERO;
          div_d   = DIV_ZERO;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (go_rise_q) begin
          state_d = S_IDLE;
          count_d = CNT_ZERO;
        end else if (pause_sync_q) begin
          // a tick in this same clock is dropped on purpose
          state_d = S_PAUSE;
        end else if (tick) begin
          if (count_q == end_val) begin
            state_d = S_DONE;
          end else if (dir_q) begin
            count_d = count_q - CNT_ONE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (go_rise_q) begin
          state_d = S_IDLE;
          count_d = CNT_ZERO;
        end else if (!pause_sync_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        // go edges are ignored here; DONE always lasts one clock
        if (auto_repeat) begin
          state_d = S_RUN;
          count_d = start_val;
          div_d   = DIV_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  // FSM state, count, divider and latched direction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= CNT_ZERO;
      div_q   <= DIV_ZERO;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      dir_q   <= dir_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
// tb_fsm_counter_ctrl
//   Directed bench for fsm_counter_ctrl. Three instances share the inputs:
//   dut_a (CLK_DIV=4, MAX=5), dut_b (CLK_DIV=4, MAX=3), dut_c (CLK_DIV=1, MAX=0).
//   Outputs are sampled 1 time unit after the rising clock edge.
module tb_fsm_counter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic go = 1'b0;
  logic pause = 1'b0;
  logic dir = 1'b0;
  logic auto_repeat = 1'b0;

  logic [3:0] count_a, count_b, count_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [1:0] state_a, state_b, state_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fsm_counter_ctrl #(.CNT_WIDTH(4), .MAX_COUNT(5), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .go(go), .pause(pause), .dir(dir),
    .auto_repeat(auto_repeat), .count(count_a), .busy(busy_a),
    .done(done_a), .state(state_a)
  );

  fsm_counter_ctrl #(.CNT_WIDTH(4), .MAX_COUNT(3), .CLK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .go(go), .pause(pause), .dir(dir),
    .auto_repeat(auto_repeat), .count(count_b), .busy(busy_b),
    .done(done_b), .state(state_b)
  );

  fsm_counter_ctrl #(.CNT_WIDTH(4), .MAX_COUNT(0), .CLK_DIV(1)) dut_c (
    .clk(clk), .rst(rst), .go(go), .pause(pause), .dir(dir),
    .auto_repeat(auto_repeat), .count(count_c), .busy(busy_c),
    .done(done_c), .state(state_c)
  );

  typedef struct {
    logic go;
    logic pause;
    logic dir;
    int   n;
    int   cnt;
    int   st;
    int   bsy;
    int   dn;
  } vec_t;

  vec_t tbl[$];

  // sequence of distinct count values seen on dut_a while busy/done
  int   seen[$];
  logic mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    go = 1'b0;
    pause = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic add(input logic g, input logic p, input logic d, input int n,
                     input int cnt, input int st, input int bsy, input int dn);
    vec_t v;
    v.go = g; v.pause = p; v.dir = d; v.n = n;
    v.cnt = cnt; v.st = st; v.bsy = bsy; v.dn = dn;
    tbl.push_back(v);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && (busy_a || done_a)) begin
        if (seen.size() == 0 || seen[$] != int'(count_a)) seen.push_back(int'(count_a));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_done;

    // Test 1: up count 0..5, one step per 4 clocks
    add(1'b1, 1'b0, 1'b0, 1,  0, 0, 0, 0);
    add(1'b0, 1'b0, 1'b0, 2,  0, 0, 0, 0);
    add(1'b0, 1'b0, 1'b0, 1,  0, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 3,  0, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 1,  1, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 4,  2, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 12, 5, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 3,  5, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 1,  5, 3, 0, 1);
    add(1'b0, 1'b0, 1'b0, 1,  5, 0, 0, 0);
    add(1'b0, 1'b0, 1'b0, 5,  5, 0, 0, 0);
    // Test 2: down count 5..0; dir changed after start must not matter
    add(1'b1, 1'b0, 1'b1, 1,  5, 0, 0, 0);
    add(1'b0, 1'b0, 1'b1, 2,  5, 0, 0, 0);
    add(1'b0, 1'b0, 1'b1, 1,  5, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 3,  5, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 1,  4, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 4,  3, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 12, 0, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 3,  0, 1, 1, 0);
    add(1'b0, 1'b0, 1'b0, 1,  0, 3, 0, 1);
    add(1'b0, 1'b0, 1'b0, 1,  0, 0, 0, 0);

    do_reset();
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_state_a", int'(state_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_state_b", int'(state_b), 0);
    chk("rst_state_c", int'(state_c), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      go = tbl[i].go;
      pause = tbl[i].pause;
      dir = tbl[i].dir;
      step(tbl[i].n);
      chk($sformatf("vec%0d_count", i), int'(count_a), tbl[i].cnt);
      chk($sformatf("vec%0d_state", i), int'(state_a), tbl[i].st);
      chk($sformatf("vec%0d_busy", i), int'(busy_a), tbl[i].bsy);
      chk($sformatf("vec%0d_done", i), int'(done_a), tbl[i].dn);
    end

    // Test 3: pause for 10 clocks at count 2, coincident tick dropped
    seen.delete();
    mon_en = 1'b1;
    dir = 1'b0;
    go = 1'b1; step(1); go = 1'b0; step(3);
    chk("t3_run", int'(state_a), 1);
    step(8);
    chk("t3_cnt2", int'(count_a), 2);
    step(1);
    pause = 1'b1;
    step(3);
    chk("t3_pause_state", int'(state_a), 2);
    chk("t3_pause_count", int'(count_a), 2);
    chk("t3_pause_busy", int'(busy_a), 1);
    step(7);
    chk("t3_pause_hold_state", int'(state_a), 2);
    chk("t3_pause_hold_count", int'(count_a), 2);
    pause = 1'b0;
    step(3);
    chk("t3_resume_state", int'(state_a), 1);
    chk("t3_resume_count", int'(count_a), 2);
    step(2);
    chk("t3_resume_step", int'(count_a), 3);
    got_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (done_a) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("t3_done_seen", int'(got_done), 1);
    chk("t3_done_count", int'(count_a), 5);
    step(1);
    chk("t3_idle", int'(state_a), 0);
    mon_en = 1'b0;
    chk("t3_seq_len", seen.size(), 6);
    for (int i = 0; i < seen.size(); i++) chk($sformatf("t3_seq%0d", i), seen[i], i);

    // Test 4: auto repeat on dut_b (MAX=3), then abort mid-run
    do_reset();
    auto_repeat = 1'b1;
    go = 1'b1; step(1); go = 1'b0; step(3);
    chk("t4_run", int'(state_b), 1);
    chk("t4_start", int'(count_b), 0);
    step(16);
    chk("t4_done1_state", int'(state_b), 3);
    chk("t4_done1_pulse", int'(done_b), 1);
    chk("t4_done1_count", int'(count_b), 3);
    step(1);
    chk("t4_reload_state", int'(state_b), 1);
    chk("t4_reload_count", int'(count_b), 0);
    chk("t4_reload_done", int'(done_b), 0);
    step(4);
    chk("t4_second_step", int'(count_b), 1);
    step(12);
    chk("t4_done2_pulse", int'(done_b), 1);
    step(1);
    chk("t4_rerun_count", int'(count_b), 0);
    step(1);
    go = 1'b1; step(1); go = 1'b0;
    chk("t4_abort_nodone0", int'(done_b), 0);
    step(1);
    chk("t4_abort_nodone1", int'(done_b), 0);
    step(1);
    chk("t4_abort_pre_state", int'(state_b), 1);
    chk("t4_abort_pre_count", int'(count_b), 1);
    step(1);
    chk("t4_abort_state", int'(state_b), 0);
    chk("t4_abort_count", int'(count_b), 0);
    chk("t4_abort_done", int'(done_b), 0);
    chk("t4_abort_busy", int'(busy_b), 0);
    step(8);
    chk("t4_abort_stay", int'(state_b), 0);
    auto_repeat = 1'b0;

    // Test 5: async reset at count 3, then restart latency
    do_reset();
    go = 1'b1; step(1); go = 1'b0; step(16);
    chk("t5_pre_count", int'(count_a), 3);
    chk("t5_pre_state", int'(state_a), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_count", int'(count_a), 0);
    chk("t5_rst_state", int'(state_a), 0);
    chk("t5_rst_done", int'(done_a), 0);
    chk("t5_rst_busy", int'(busy_a), 0);
    step(1);
    rst = 1'b0;
    step(1);
    go = 1'b1; step(1); go = 1'b0; step(2);
    chk("t5_latency_idle", int'(state_a), 0);
    step(1);
    chk("t5_latency_run", int'(state_a), 1);
    chk("t5_restart_count", int'(count_a), 0);

    // Test 6: CLK_DIV=1, MAX=0 on dut_c
    do_reset();
    go = 1'b1; step(1); go = 1'b0; step(3);
    chk("t6_run", int'(state_c), 1);
    chk("t6_run_busy", int'(busy_c), 1);
    step(1);
    chk("t6_done_state", int'(state_c), 3);
    chk("t6_done_pulse", int'(done_c), 1);
    chk("t6_done_count", int'(count_c), 0);
    step(1);
    chk("t6_idle", int'(state_c), 0);
    chk("t6_idle_done", int'(done_c), 0);
    chk("t6_idle_count", int'(count_c), 0);

    // Test 7: pause held in IDLE is ignored; start goes RUN then PAUSE
    do_reset();
    pause = 1'b1;
    step(5);
    chk("t7_idle_pause", int'(state_a), 0);
    go = 1'b1; step(1); go = 1'b0; step(2);
    chk("t7_still_idle", int'(state_a), 0);
    step(1);
    chk("t7_run_first", int'(state_a), 1);
    step(1);
    chk("t7_then_pause", int'(state_a), 2);
    pause = 1'b0;
    step(3);
    chk("t7_resume", int'(state_a), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
